// File: rtl/crossbar_slave_channel_if.sv
// Bus bundle between a slave's session engine, the masters and the slave port.
interface crossbar_slave_channel_if #(
  parameter int unsigned QTY_OF_DEVICES = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32
);
  // Arbiter and master side
  logic [QTY_OF_DEVICES-1:0]            grant;
  logic [QTY_OF_DEVICES-1:0]            m_req;
  logic [QTY_OF_DEVICES*ADDR_WIDTH-1:0] m_addr;
  logic [QTY_OF_DEVICES-1:0]            m_cmd;
  logic [QTY_OF_DEVICES*DATA_WIDTH-1:0] m_wdata;
  logic [QTY_OF_DEVICES-1:0]            m_ack;
  logic [QTY_OF_DEVICES-1:0]            m_resp;
  logic [DATA_WIDTH-1:0]                m_rdata;

  // Slave port side
  logic                                 s_req;
  logic [ADDR_WIDTH-1:0]                s_addr;
  logic                                 s_cmd;
  logic [DATA_WIDTH-1:0]                s_wdata;
  logic                                 s_ack;
  logic                                 s_resp;
  logic [DATA_WIDTH-1:0]                s_rdata;

  // Status back to the arbiter
  logic                                 session_is_finished;
  logic                                 grant_error;

  // Session engine view
  modport slave (
    input  grant, m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata,
           session_is_finished, grant_error
  );

  // Surrounding fabric view
  modport master (
    output grant, m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata,
           session_is_finished, grant_error
  );
endinterface

// File: rtl/crossbar_slave_channel.sv
// Per-slave session engine: latches the granted master's request, runs the
// slave req/ack and read-response handshake, and routes replies to the owner.
module crossbar_slave_channel #(
  parameter int unsigned QTY_OF_DEVICES = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RESP_TIMEOUT   = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input logic                     clk,
  input logic                     rst,
  crossbar_slave_channel_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(RESP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;

  state_t                    state;
  state_t                    state_next;

  logic [QTY_OF_DEVICES-1:0] owner;
  logic [CNT_W-1:0]          cnt;
  logic                      grant_onehot;
  logic                      grant_bad;
  logic                      start;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic                      sel_cmd;
  logic [DATA_WIDTH-1:0]     sel_wdata;

  logic [QTY_OF_DEVICES-1:0] m_ack_c;
  logic [QTY_OF_DEVICES-1:0] m_resp_c;
  logic [DATA_WIDTH-1:0]     m_rdata_c;

  logic                      s_req_q;
  logic [ADDR_WIDTH-1:0]     s_addr_q;
  logic                      s_cmd_q;
  logic [DATA_WIDTH-1:0]     s_wdata_q;
  logic                      fin_q;
  logic                      gerr_q;

  // Grant qualification and mux of the granted master's request fields
  always_comb begin
    grant_onehot = ($countones(bus.grant) == 1);
    grant_bad    = (bus.grant != '0) && !grant_onehot;
    start        = grant_onehot && (|(bus.grant & bus.m_req));
    sel_addr     = '0;
    sel_cmd      = 1'b0;
    sel_wdata    = '0;
    for (int i = 0; i < int'(QTY_OF_DEVICES); i++) begin
      if (bus.grant[i]) begin
        sel_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cmd   = bus.m_cmd[i];
        sel_wdata = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and same-cycle strobes routed to the owner
  always_comb begin
    state_next = state;
    m_ack_c    = '0;
    m_resp_c   = '0;
    m_rdata_c  = '0;
    case (state)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        if (bus.s_ack) begin
          m_ack_c    = owner;
          state_next = s_cmd_q ? FIN : RESP;
        end
      end
      RESP: begin
        // A real response wins even on the cycle the timeout would fire
        if (bus.s_resp) begin
          m_resp_c   = owner;
          m_rdata_c  = bus.s_rdata;
          state_next = FIN;
        end else if (cnt == TIMEOUT_CNT) begin
          m_resp_c   = owner;
          m_rdata_c  = ERR_DATA;
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Session latches, slave bus registers, response counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      cnt       <= '0;
      s_req_q   <= 1'b0;
      s_addr_q  <= '0;
      s_cmd_q   <= 1'b0;
      s_wdata_q <= '0;
      fin_q     <= 1'b0;
      gerr_q    <= 1'b0;
    end else begin
      s_req_q <= (state_next == REQ);
      fin_q   <= (state_next == FIN);
      if ((state == IDLE) && grant_bad) gerr_q <= 1'b1;
      if ((state == IDLE) && start) begin
        owner     <= bus.grant;
        s_addr_q  <= sel_addr;
        s_cmd_q   <= sel_cmd;
        s_wdata_q <= sel_wdata;
      end
      // Counter saturates at the timeout value, so it can never wrap
      if (state == REQ) begin
        cnt <= '0;
      end else if ((state == RESP) && !bus.s_resp && (cnt != TIMEOUT_CNT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.m_ack               = m_ack_c;
  assign bus.m_resp              = m_resp_c;
  assign bus.m_rdata             = m_rdata_c;
  assign bus.s_req               = s_req_q;
  assign bus.s_addr              = s_addr_q;
  assign bus.s_cmd               = s_cmd_q;
  assign bus.s_wdata             = s_wdata_q;
  assign bus.session_is_finished = fin_q;
  assign bus.grant_error         = gerr_q;

endmodule

// File: tb/tb_crossbar_slave_channel.sv
// Bench for crossbar_slave_channel: sessions are scripted cycle by cycle from
// their parameters (ack delay, response slot, timeout) and the expected output
// of every cycle is derived from those parameters.
module tb_crossbar_slave_channel;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  crossbar_slave_channel_if #(.QTY_OF_DEVICES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  crossbar_slave_channel #(
    .QTY_OF_DEVICES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RESP_TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic          e_sreq, e_fin, e_sbus_chk, e_scmd;
  logic [N-1:0]  e_ack, e_resp;
  logic [DW-1:0] e_rdata, e_swdata;
  logic [AW-1:0] e_saddr;
  logic          gerr = 1'b0;
  logic          gerr_next = 1'b0;

  // Observed event timestamps for the literal checks
  int cyc = 0;
  int t_rise, t_ack, t_resp, t_fin;
  logic          prev_sreq = 1'b0;
  logic [N-1:0]  last_ack, last_resp;
  logic [DW-1:0] last_rdata, last_swdata;
  logic [AW-1:0] last_saddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the expectation set by the stimulus
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("s_req", 32'(bus.s_req), 32'(e_sreq));
      chk("m_ack", 32'(bus.m_ack), 32'(e_ack));
      chk("m_resp", 32'(bus.m_resp), 32'(e_resp));
      chk("m_rdata", bus.m_rdata, e_rdata);
      chk("session_is_finished", 32'(bus.session_is_finished), 32'(e_fin));
      chk("grant_error", 32'(bus.grant_error), 32'(gerr));
      if (e_sbus_chk) begin
        chk("s_addr", bus.s_addr, e_saddr);
        chk("s_cmd", 32'(bus.s_cmd), 32'(e_scmd));
        chk("s_wdata", bus.s_wdata, e_swdata);
      end
    end
    if (bus.s_req === 1'b1 && prev_sreq !== 1'b1) t_rise = cyc;
    if (bus.m_ack != '0) begin
      t_ack       = cyc;
      last_ack    = bus.m_ack;
      last_saddr  = bus.s_addr;
      last_swdata = bus.s_wdata;
    end
    if (bus.m_resp != '0) begin
      t_resp     = cyc;
      last_resp  = bus.m_resp;
      last_rdata = bus.m_rdata;
    end
    if (bus.session_is_finished === 1'b1) t_fin = cyc;
    prev_sreq = bus.s_req;
  end

  task automatic clear_caps();
    t_rise = -100; t_ack = -100; t_resp = -100; t_fin = -100;
    last_ack = '0; last_resp = '0; last_rdata = '0; last_swdata = '0; last_saddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    gerr = gerr_next;
  endtask

  task automatic exp_idle();
    e_sreq = 1'b0; e_fin = 1'b0; e_sbus_chk = 1'b0; e_ack = '0; e_resp = '0; e_rdata = '0;
    e_saddr = '0; e_scmd = 1'b0; e_swdata = '0;
  endtask

  task automatic exp_zero_sbus();
    e_sbus_chk = 1'b1; e_saddr = '0; e_scmd = 1'b0; e_swdata = '0;
  endtask

  task automatic rand_inputs();
    bus.m_req   = N'($urandom);
    bus.m_cmd   = N'($urandom);
    bus.m_addr  = {$urandom, $urandom, $urandom, $urandom};
    bus.m_wdata = {$urandom, $urandom, $urandom, $urandom};
    bus.s_ack   = 1'($urandom);
    bus.s_resp  = 1'($urandom);
    bus.s_rdata = $urandom;
  endtask

  function automatic logic [N-1:0] bad_grant();
    logic [N-1:0] g;
    do g = N'($urandom); while ($countones(g) < 2);
    return g;
  endfunction

  // kind 0: no grant; 1: grant to a non-requesting master; 2: non-one-hot grant
  task automatic idle_cycle(input int kind);
    int k;
    k = int'($urandom_range(0, N-1));
    rand_inputs();
    exp_idle();
    case (kind)
      0: bus.grant = '0;
      1: begin bus.grant = N'(1) << k; bus.m_req[k] = 1'b0; end
      default: begin bus.grant = bad_grant(); gerr_next = 1'b1; end
    endcase
    tick();
  endtask

  task automatic do_reset();
    rand_inputs(); exp_idle(); bus.grant = '0; rst = 1'b1; gerr_next = 1'b0;
    tick();
    rst = 1'b0; rand_inputs(); exp_idle(); exp_zero_sbus(); bus.grant = '0;
    tick();
  endtask

  // One session: ack after ack_dly extra REQ cycles; read response in RESP slot r
  // (r > TO means the slave never answers); rst_at aborts in that RESP slot.
  task automatic session(input int k, input logic cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int ack_dly, input int r,
                         input logic [DW-1:0] rdata, input bit mid_change, input int rst_at);
    logic [N-1:0] own;
    int last;
    own  = N'(1) << k;
    last = (r < int'(TO)) ? r : int'(TO);
    rand_inputs(); exp_idle();
    bus.grant = own; bus.m_req[k] = 1'b1; bus.m_cmd[k] = cmd;
    bus.m_addr[k*AW +: AW] = addr; bus.m_wdata[k*DW +: DW] = wdata;
    tick();
    for (int i = 0; i <= ack_dly; i++) begin
      rand_inputs(); exp_idle();
      bus.grant = N'($urandom);
      if (mid_change) begin bus.grant = N'(1); bus.m_req[k] = 1'b0; end
      bus.s_ack = (i == ack_dly);
      e_sreq = 1'b1; e_sbus_chk = 1'b1; e_saddr = addr; e_scmd = cmd; e_swdata = wdata;
      if (i == ack_dly) e_ack = own;
      tick();
    end
    if (!cmd) begin
      for (int i = 0; i <= last; i++) begin
        rand_inputs(); exp_idle();
        bus.grant  = N'($urandom);
        bus.s_resp = (i == r);
        if (i == r) bus.s_rdata = rdata;
        if (i == rst_at) begin
          bus.s_resp = 1'b0; rst = 1'b1; gerr_next = 1'b0;
          tick();
          rst = 1'b0; rand_inputs(); exp_idle(); exp_zero_sbus();
          bus.grant = '0; bus.s_resp = 1'b1; bus.s_ack = 1'b1;
          tick();
          return;
        end
        if (i == last) begin
          e_resp  = own;
          e_rdata = (r <= int'(TO)) ? rdata : ERR;
        end
        tick();
      end
    end
    // FIN: a fresh valid grant here must not be sampled
    rand_inputs(); exp_idle();
    bus.grant = N'(1) << $urandom_range(0, N-1); bus.m_req = '1;
    e_fin = 1'b1;
    tick();
  endtask

  initial begin
    int k, ack_dly, r, last, rst_at;
    logic cmd;
    rst = 1'b1;
    bus.grant = '0; bus.m_req = '0; bus.m_cmd = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_ack = 1'b0; bus.s_resp = 1'b0; bus.s_rdata = '0;
    exp_idle();
    tick();
    chk_en = 1'b1; exp_idle(); exp_zero_sbus();
    tick();
    rst = 1'b0; exp_idle(); exp_zero_sbus();
    tick();

    // Write, master 2, ack on the second REQ cycle
    clear_caps();
    session(2, 1'b1, 32'h4000_0010, 32'h0000_1234, 1, 0, '0, 1'b0, -1);
    idle_cycle(0);
    chk("lit_wr_saddr", last_saddr, 32'h4000_0010);
    chk("lit_wr_wdata", last_swdata, 32'h0000_1234);
    chk("lit_wr_ack", 32'(last_ack), 32'h4);
    chk("lit_wr_ack_lat", 32'(t_ack - t_rise), 32'd1);
    chk("lit_wr_fin_lat", 32'(t_fin - t_ack), 32'd1);

    // Read, master 1, response 3 cycles after ack
    clear_caps();
    session(1, 1'b0, $urandom, $urandom, 0, 2, 32'hCAFE_F00D, 1'b0, -1);
    idle_cycle(0);
    chk("lit_rd_resp", 32'(last_resp), 32'h2);
    chk("lit_rd_rdata", last_rdata, 32'hCAFE_F00D);
    chk("lit_rd_resp_lat", 32'(t_resp - t_ack), 32'd3);
    chk("lit_rd_fin_lat", 32'(t_fin - t_resp), 32'd1);

    // Read timeout, master 0
    clear_caps();
    session(0, 1'b0, $urandom, $urandom, 0, 99, '0, 1'b0, -1);
    idle_cycle(0);
    chk("lit_to_resp", 32'(last_resp), 32'h1);
    chk("lit_to_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("lit_to_lat", 32'(t_resp - t_ack), 32'd5);

    // Grant moves and owner drops its request mid-session
    clear_caps();
    session(3, 1'b1, $urandom, $urandom, 2, 0, '0, 1'b1, -1);
    idle_cycle(0);
    chk("lit_mid_ack", 32'(last_ack), 32'h8);
    chk("lit_mid_ack_lat", 32'(t_ack - t_rise), 32'd2);

    // Non-one-hot grant
    rand_inputs(); exp_idle(); bus.grant = 4'b0110; bus.m_req = 4'b0110; gerr_next = 1'b1;
    tick();
    idle_cycle(0);
    chk("lit_gerr_set", 32'(bus.grant_error), 32'd1);
    do_reset();
    chk("lit_gerr_clr", 32'(bus.grant_error), 32'd0);

    // Reset in the middle of a read's response wait
    clear_caps();
    session(1, 1'b0, $urandom, $urandom, 1, 99, '0, 1'b0, 2);
    idle_cycle(0);
    idle_cycle(0);
    chk("lit_rst_no_fin", 32'(t_fin), 32'(-100));
    chk("lit_rst_no_resp", 32'(t_resp), 32'(-100));

    // Randomised sessions with idle gaps, bad grants and occasional aborts
    repeat (150) begin
      k       = int'($urandom_range(0, N-1));
      cmd     = 1'($urandom);
      ack_dly = int'($urandom_range(0, 3));
      r       = int'($urandom_range(0, 6));
      last    = (r < int'(TO)) ? r : int'(TO);
      rst_at  = -1;
      if (!cmd && last >= 1 && $urandom_range(0, 9) == 0)
        rst_at = int'($urandom_range(0, last - 1));
      session(k, cmd, $urandom, $urandom, ack_dly, r, $urandom, 1'($urandom_range(0, 3) == 0), rst_at);
      repeat ($urandom_range(0, 2)) idle_cycle(($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    idle_cycle(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_slave_channel.md
# crossbar_slave_channel

Per-slave session engine that sits directly downstream of each slave's round-robin arbiter in the 4x4 cross bar. It takes the arbiter's one-hot grant, latches the winning master's request, drives the slave port through the request/ack and read-response handshake, and routes ack/resp/rdata back to the owning master. On completion it pulses `session_is_finished` so the arbiter can rotate. The cross bar instantiates one per slave.

## Interface
- `QTY_OF_DEVICES`, 4, number of masters; grant width.
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `RESP_TIMEOUT`, 255, max cycles to wait for slave `resp` on a read; range 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF, rdata returned on a read timeout.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `grant`  in  QTY_OF_DEVICES  one-hot grant from this slave's arbiter.
- `m_req`  in  QTY_OF_DEVICES  request bit from each master.
- `m_addr`  in  QTY_OF_DEVICES*ADDR_WIDTH  flattened master addresses; master k at slice k.
- `m_cmd`  in  QTY_OF_DEVICES  per-master command; 0 = read, 1 = write.
- `m_wdata`  in  QTY_OF_DEVICES*DATA_WIDTH  flattened write data.
- `m_ack`  out  QTY_OF_DEVICES  request-accepted strobe to the owner.
- `m_resp`  out  QTY_OF_DEVICES  read-response strobe to the owner.
- `m_rdata`  out  DATA_WIDTH  read data, shared; valid only with `m_resp`.
- `s_req`, `s_addr`, `s_cmd`, `s_wdata`  out  1/ADDR_WIDTH/1/DATA_WIDTH  slave request bus.
- `s_ack`  in  1  slave accepted request.
- `s_resp`  in  1  slave read response valid.
- `s_rdata`  in  DATA_WIDTH  slave read data.
- `session_is_finished`  out  1  1-cycle pulse to the arbiter at session end.
- `grant_error`  out  1  sticky; set when `grant` is seen non-one-hot in IDLE.

## Operation
- States: IDLE, REQ, RESP, FIN.
- IDLE: if `grant` is one-hot (index k) and `m_req[k]`=1, latch owner=k, `m_addr[k]`, `m_cmd[k]`, `m_wdata[k]` into registers and go to REQ. If `grant`≠0 is not one-hot, stay in IDLE and set `grant_error`. A zero grant, or a grant to a master whose `m_req` is low, is ignored.
- REQ: `s_req`=1 with the latched addr/cmd/wdata held stable. On `s_ack`=1:
  - `m_ack[owner]`=1 combinationally in the same cycle.
  - Write: go to FIN.
  - Read: clear the timeout counter and go to RESP.
- RESP: `m_resp[owner]`=`s_resp` and `m_rdata`=`s_rdata`, both combinational.
  - On `s_resp`=1: go to FIN.
  - Otherwise the counter increments. When the counter reaches `RESP_TIMEOUT`-1 without `s_resp`, the next cycle drives `m_resp[owner]`=1 with `m_rdata`=`ERR_DATA`, then goes to FIN.
- FIN: `session_is_finished`=1 for exactly one cycle, then IDLE. `grant` is not sampled in FIN.
- Owner is frozen for the whole session. Master `m_req`, `m_addr` or `grant` changing mid-session has no effect.
- `s_resp` outside RESP is ignored. `s_ack` outside REQ is ignored.
- Counter is 8 bits and never wraps; it saturates at the timeout.
- `rst` in any state forces IDLE on the next edge, clears owner, counter and `grant_error`, and aborts the session with no `session_is_finished` pulse.

## Timing
- Reset values: `s_req`=0, `s_addr`=0, `s_cmd`=0, `s_wdata`=0, `m_ack`=0, `m_resp`=0, `m_rdata`=0, `session_is_finished`=0, `grant_error`=0, state=IDLE.
- `s_req` and the s-bus are registered. `s_req` rises the cycle after the grant+req qualifying edge, i.e. 1 cycle latency.
- `s_req` falls on the edge after `s_ack`. No back-to-back `s_req` across sessions: there are at least 2 low cycles (FIN + IDLE sample).
- Write session with immediate ack: grant cycle, REQ (ack), FIN = 3 cycles total.
- Read session with resp d cycles after ack: 3 + d cycles.
- `m_ack`/`m_resp` are single-cycle, at most one bit set, and never both in the same cycle.
- `m_rdata`=0 whenever `m_resp`=0.

## Test plan
- Write: `grant`=4'b0100, `m_req[2]`=1, addr 0x4000_0010, wdata 0x1234, `s_ack` on the 2nd REQ cycle. Expect `s_addr`/`s_wdata` match, `m_ack`=4'b0100 for 1 cycle, then `session_is_finished` pulse, back to IDLE.
- Read: master 1, `s_resp` 3 cycles after ack with `s_rdata`=0xCAFE_F00D. Expect `m_resp`=4'b0010 and `m_rdata`=0xCAFE_F00D in the same cycle, then the FIN pulse.
- Timeout: `RESP_TIMEOUT`=4, `s_resp` never asserted. Expect `m_resp[owner]`=1 with `m_rdata`=0xDEAD_BEEF 4 cycles after entering RESP, then FIN.
- Mid-session grant change: during REQ switch `grant` to 4'b0001 and drop `m_req` of the owner. Expect the owner unchanged, `s_req` held until `s_ack`, and `m_ack` only to the original owner.
- Bad grant: `grant`=4'b0110 in IDLE. Expect no `s_req`, `grant_error`=1 sticky, and clear on `rst`.
- Reset mid-RESP: assert `rst` for 1 cycle. Expect all outputs 0 next cycle, no `session_is_finished`, and a late `s_resp` ignored.
